// File: rtl/inst_fetch_resp.sv
// Purpose  : memory-side fetch responder; reads 4 bytes from a byte-wide sync memory, returns a LE word.
// Latency  : miss = 6 cycles accept->rdy; hit (INST_LAST_HIT_EN) = 1 cycle; throughput 1 word / 7 cycles.
// Backpr.  : core holds rom_ce_i/rom_addr_i until rom_rdy_o; dropping rom_ce_i mid-fetch aborts it.
//
// Ports: clk, rst (async active-low); rom_ce_i/rom_addr_i request; rom_data_o/rom_rdy_o completion;
//        mem_a_o byte address to program memory; mem_din_i = mem[mem_a_o of previous cycle].
// Optional: define INST_LAST_HIT_EN for a one-entry last-fetched-word buffer (hit path skips memory).
module inst_fetch_resp #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              rom_rdy_o,
  output logic [ADDR_W-1:0] mem_a_o,
  input  logic [7:0]        mem_din_i
);

  localparam int WA_W = ADDR_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RD, S_DONE} state_e;

  state_e            state_q,  state_d;
  logic [WA_W-1:0]   base_q,   base_d;
  logic [1:0]        cnt_q,    cnt_d;
  logic [23:0]       shadow_q, shadow_d;
  logic [31:0]       data_q,   data_d;
  logic              rdy_q,    rdy_d;
  logic [ADDR_W-1:0] mem_a_q,  mem_a_d;

  logic [WA_W-1:0]   req_wa;
  logic              hit;
  logic              miss_done;
  logic              unused_addr_bits;

  assign req_wa           = rom_addr_i[ADDR_W-1:2];
  assign unused_addr_bits = ^{rom_addr_i[31:ADDR_W], rom_addr_i[1:0]};

  // Last byte arrives on mem_din_i in the cnt=3 RD cycle; a dropped ce there still aborts.
  assign miss_done = (state_q == S_RD) && rom_ce_i && (cnt_q == 2'd3);

`ifdef INST_LAST_HIT_EN
  logic            hbuf_vld_q;
  logic [WA_W-1:0] hbuf_wa_q;

  assign hit = hbuf_vld_q && (hbuf_wa_q == req_wa);

  // Only a completed miss refreshes the buffer; aborts leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hbuf_vld_q <= 1'b0;
      hbuf_wa_q  <= '0;
    end else if (miss_done) begin
      hbuf_vld_q <= 1'b1;
      hbuf_wa_q  <= base_q;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    rdy_d    = 1'b0;
    mem_a_d  = mem_a_q;
    case (state_q)
      S_IDLE: begin
        if (rom_ce_i) begin
          if (hit) begin
            // rom_data_o already holds this word; no memory access.
            state_d = S_DONE;
            rdy_d   = 1'b1;
          end else begin
            base_d  = req_wa;
            mem_a_d = {req_wa, 2'b00};
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (!rom_ce_i) begin
          state_d = S_IDLE;
        end else begin
          mem_a_d = {base_q, 2'b01};
          cnt_d   = 2'd0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (!rom_ce_i) begin
          state_d = S_IDLE;
        end else begin
          case (cnt_q)
            2'd0:    shadow_d[7:0]   = mem_din_i;
            2'd1:    shadow_d[15:8]  = mem_din_i;
            2'd2:    shadow_d[23:16] = mem_din_i;
            default: shadow_d        = shadow_q;
          endcase
          // Address runs one ahead of capture, so it stops at base+3.
          if (cnt_q < 2'd2) mem_a_d = mem_a_q + ADDR_W'(1);
          if (cnt_q == 2'd3) begin
            data_d  = {mem_din_i, shadow_q};
            rdy_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      cnt_q    <= 2'd0;
      shadow_q <= '0;
      data_q   <= '0;
      rdy_q    <= 1'b0;
      mem_a_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      mem_a_q  <= mem_a_d;
    end
  end

  assign rom_data_o = data_q;
  assign rom_rdy_o  = rdy_q;
  assign mem_a_o    = mem_a_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Purpose  : self-checking bench for inst_fetch_resp (vector table, hand corner cases, random fetches).
// Latency  : expects miss rdy 6 cycles after accept, hit rdy 1 cycle after accept.
// Backpr.  : bench acts as the core: holds request until rdy, may abort by dropping ce.
module tb_inst_fetch_resp;

  localparam int ADDR_W = 17;
`ifdef INST_LAST_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif
  localparam int LREP = HIT_EN ? 1 : 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic [31:0]       addr;
  logic [31:0]       data;
  logic              rdy;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        din;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic prev_rdy = 1'b0;

  // Model of the last-hit buffer: word address of last completed miss.
  bit               model_vld = 1'b0;
  logic [ADDR_W-3:0] model_wa  = '0;

  inst_fetch_resp #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (ce),
    .rom_addr_i (addr),
    .rom_data_o (data),
    .rom_rdy_o  (rdy),
    .mem_a_o    (mem_a),
    .mem_din_i  (din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) din <= mem[mem_a];

  always @(negedge clk) begin
    if (rdy) begin
      checks++;
      if (prev_rdy) begin
        failures++;
        $display("FAIL rdy_double actual=two consecutive cycles required=single pulse (cyc %0d)", cyc);
      end
    end
    prev_rdy = rdy;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [ADDR_W-1:0] b;
    b = {a[ADDR_W-1:2], 2'b00};
    return {mem[b + 3], mem[b + 2], mem[b + 1], mem[b]};
  endfunction

  function automatic int ref_lat(input logic [31:0] a);
    return (HIT_EN && model_vld && model_wa == a[ADDR_W-1:2]) ? 1 : 6;
  endfunction

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_w, input int exp_lat,
                          output int rdy_cyc);
    logic [ADDR_W-1:0] base, a0;
    int n;
    bit seq_ok;
    @(negedge clk);
    ce = 1'b1;
    addr = a;
    base = {a[ADDR_W-1:2], 2'b00};
    a0 = mem_a;
    n = 0;
    seq_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (exp_lat == 6 && n <= 4 && mem_a !== ADDR_W'(base + n - 1)) seq_ok = 1'b0;
    end while (!rdy && n < 20);
    check("latency", n, exp_lat);
    check("data", data, exp_w);
    if (exp_lat == 1) check("mem_a_hold", mem_a, a0);
    else              check("mem_a_seq", seq_ok, 1);
    rdy_cyc = cyc;
    if (exp_lat == 6) begin
      model_vld = 1'b1;
      model_wa  = a[ADDR_W-1:2];
    end
  endtask

  // Start a miss, drop ce during cycle T+k, confirm nothing completes.
  task automatic abort_fetch(input logic [31:0] a, input int k);
    logic [31:0] d0;
    bit any;
    @(negedge clk);
    ce = 1'b1;
    addr = a;
    d0 = data;
    any = 1'b0;
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      any |= rdy;
      if (i == k) ce = 1'b0;
    end
    @(negedge clk);
    any |= rdy;
    check("abort_no_rdy", any, 0);
    check("abort_data_hold", data, d0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    int          lat;
    bit          b2b;
  } vec_t;

  initial begin
    vec_t vecs [9];
    int rc, prev_rc;
    bit any;
    logic [31:0] ra;

    rst = 1'b1;
    ce = 1'b0;
    addr = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
    mem[17'h100] = 8'h13; mem[17'h101] = 8'h05; mem[17'h102] = 8'h10; mem[17'h103] = 8'h00;

    vecs[0] = '{32'h0000_0100, 32'h0010_0513, 6,    1'b0};
    vecs[1] = '{32'hFFFE_0102, 32'h0010_0513, LREP, 1'b0};
    vecs[2] = '{32'h0000_0104, ref_word(32'h104), 6, 1'b0};
    vecs[3] = '{32'h0000_0000, ref_word(32'h0),   6, 1'b0};
    vecs[4] = '{32'h0000_0004, ref_word(32'h4),   6, 1'b1};
    vecs[5] = '{32'h0000_0008, ref_word(32'h8),   6, 1'b1};
    vecs[6] = '{32'h0000_0100, 32'h0010_0513, 6,    1'b0};
    vecs[7] = '{32'h0000_0100, 32'h0010_0513, LREP, 1'b0};
    vecs[8] = '{32'h0000_0104, ref_word(32'h104), 6, 1'b0};

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rdy", rdy, 0);
    check("reset_data", data, 0);
    check("reset_mem_a", mem_a, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_rdy", rdy, 0);

    prev_rc = 0;
    for (int i = 0; i < 9; i++) begin
      if (!vecs[i].b2b) begin
        @(negedge clk);
        ce = 1'b0;
      end
      do_fetch(vecs[i].addr, vecs[i].word, vecs[i].lat, rc);
      if (vecs[i].b2b) check("b2b_spacing", rc - prev_rc, 7);
      prev_rc = rc;
    end

    // Abort at T+3, then 0x104 (still buffered: abort must not touch the buffer).
    @(negedge clk);
    ce = 1'b0;
    abort_fetch(32'h200, 3);
    do_fetch(32'h104, ref_word(32'h104), ref_lat(32'h104), rc);
    @(negedge clk);
    ce = 1'b0;
    abort_fetch(32'h10C, 5);
    do_fetch(32'h10C, ref_word(32'h10C), ref_lat(32'h10C), rc);

    // Reset in the middle of a miss.
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    ce = 1'b1;
    addr = 32'h300;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rdy", rdy, 0);
    check("midrst_data", data, 0);
    check("midrst_mem_a", mem_a, 0);
    ce = 1'b0;
    model_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    any = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any |= rdy;
    end
    check("midrst_no_stale_rdy", any, 0);
    do_fetch(32'h300, ref_word(32'h300), 6, rc);

    // Random fetches, some reusing the buffered word, some aborted.
    for (int it = 0; it < 40; it++) begin
      ra = $urandom;
      if ($urandom_range(0, 2) == 0) ra[ADDR_W-1:2] = model_wa;
      if (ref_lat(ra) == 6 && $urandom_range(0, 4) == 0) begin
        @(negedge clk);
        ce = 1'b0;
        abort_fetch(ra, $urandom_range(1, 5));
      end else begin
        do_fetch(ra, ref_word(ra), ref_lat(ra), rc);
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        ce = 1'b0;
      end
    end

    @(negedge clk);
    ce = 1'b0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
